read_logic_gen: RTL

Tile-granular BRAM read sequencer for the arbiter's read path: the consumer-side counterpart of the strided tile writer. On each `start_read` pulse it streams one tile of `NUM_READS_PER_TILE` words out of BRAM at stride `ADDR_STRIDE`, hides BRAM read latency with a small credit-controlled output FIFO, and presents words on a valid/ready stream toward the systolic-array loaders. It pulses `read_done` when the last word of the tile has been accepted downstream.

---
 rtl/read_logic_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/read_logic_gen.sv
// read_logic_gen
// Tile-granular BRAM read sequencer. A start_read_i pulse in IDLE streams one
// tile of NUM_READS_PER_TILE words from BRAM at stride ADDR_STRIDE. A small
// credit-controlled FIFO hides the BRAM read latency. Words leave on a
// valid/ready stream, and read_done_o pulses once the whole tile has been
// accepted downstream.
//
// Ports
//   clk                   clock
//   rst_n                 asynchronous active-low reset
//   start_read_i          pulse: read the next tile (honoured only in IDLE)
//   reset_addr_counter_i  pulse: clear the tile pointer
//   bram_addr_o           BRAM read address (combinational from registers)
//   bram_en_o             BRAM read enable, one word per high cycle
//   bram_dout_i           BRAM read data, valid BRAM_LATENCY cycles after enable
//   rd_data_o             FIFO head word
//   rd_valid_o            rd_data_o is valid
//   rd_ready_i            consumer accepts when rd_valid_o && rd_ready_i
//   busy_o                high whenever not IDLE
//   read_done_o           one-cycle pulse when the tile is fully delivered
module read_logic_gen #(
  parameter int NUM_READS_PER_TILE = 16,
  parameter int ADDR_WIDTH         = 16,
  parameter int ADDR_STRIDE        = 24,
  parameter int DATA_WIDTH         = 256,
  parameter int BRAM_LATENCY       = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_read_i,
  input  logic                  reset_addr_counter_i,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic                  bram_en_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  busy_o,
  output logic                  read_done_o
);

  localparam int OW = $clog2(NUM_READS_PER_TILE);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [OW-1:0]         LAST_OFF  = OW'(NUM_READS_PER_TILE - 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]         PTR_LAST  = PW'(FIFO_DEPTH - 1);
  // Address steps folded to ADDR_WIDTH: modulo-2^ADDR_WIDTH arithmetic gives
  // the same result as computing at full width and truncating.
  localparam logic [ADDR_WIDTH-1:0] TILE_STEP = ADDR_WIDTH'(NUM_READS_PER_TILE * ADDR_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READING = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [8:0]              tile_ptr_q, tile_ptr_d;
  logic [OW-1:0]           read_offset_q, read_offset_d;
  logic [CW-1:0]           count_q, count_d;        // in flight + FIFO occupancy
  logic [BRAM_LATENCY-1:0] vpipe_q;                 // tags returning BRAM data
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;

  logic issue_s;
  logic push_s;
  logic pop_s;

  // A request goes out only while a FIFO slot is guaranteed for its data.
  assign issue_s = (state_q == S_READING) && (count_q < DEPTH_C);
  assign push_s  = vpipe_q[BRAM_LATENCY-1];
  assign pop_s   = (fifo_cnt_q != {CW{1'b0}}) && rd_ready_i;

  assign bram_addr_o = (ADDR_WIDTH'(tile_ptr_q) * TILE_STEP)
                     + (ADDR_WIDTH'(read_offset_q) * WORD_STEP);
  assign bram_en_o   = issue_s;
  assign rd_data_o   = fifo_mem_q[rd_ptr_q];
  assign rd_valid_o  = (fifo_cnt_q != {CW{1'b0}});
  assign busy_o      = (state_q != S_IDLE);
  assign read_done_o = (state_q == S_DONE);

  // Next-state logic of the tile sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_read_i) state_d = S_READING;
        else              state_d = S_IDLE;
      end
      S_READING: begin
        if (issue_s && (read_offset_q == LAST_OFF)) state_d = S_DRAIN;
        else                                        state_d = S_READING;
      end
      S_DRAIN: begin
        if (count_q == {CW{1'b0}}) state_d = S_DONE;
        else                       state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the address counters, credit count and FIFO pointers.
  always_comb begin
    read_offset_d = read_offset_q;
    tile_ptr_d    = tile_ptr_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    if (state_q == S_DONE) begin
      read_offset_d = {OW{1'b0}};
    end else if (issue_s) begin
      read_offset_d = read_offset_q + OW'(1);
    end else begin
      read_offset_d = read_offset_q;
    end

    // A clear arriving together with the end-of-tile advance wins.
    if (reset_addr_counter_i) begin
      tile_ptr_d = 9'd0;
    end else if (state_q == S_DONE) begin
      tile_ptr_d = tile_ptr_q + 9'd1;
    end else begin
      tile_ptr_d = tile_ptr_q;
    end

    case ({issue_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s) begin
      if (wr_ptr_q == PTR_LAST) wr_ptr_d = {PW{1'b0}};
      else                      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      if (rd_ptr_q == PTR_LAST) rd_ptr_d = {PW{1'b0}};
      else                      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State, counters, FIFO pointers and the BRAM-latency valid pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tile_ptr_q    <= 9'd0;
      read_offset_q <= {OW{1'b0}};
      count_q       <= {CW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      fifo_cnt_q    <= {CW{1'b0}};
      vpipe_q       <= {BRAM_LATENCY{1'b0}};
    end else begin
      state_q       <= state_d;
      tile_ptr_q    <= tile_ptr_d;
      read_offset_q <= read_offset_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      vpipe_q[0]    <= issue_s;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
    end
  end

  // FIFO storage; cleared on reset so rd_data_o starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= bram_dout_i;
    end
  end

endmodule
